// File: rtl/fsm_pattern_sequencer_if.sv
// Host and FSM-side signal bundle for fsm_pattern_sequencer.
// The mismatch_cnt signal exists only when SEQ_MISMATCH_CNT_EN is defined.
interface fsm_pattern_sequencer_if #(
  parameter int unsigned LEN = 8
`ifdef SEQ_MISMATCH_CNT_EN
  , parameter int unsigned CW = $clog2(LEN + 1)
`endif
);
  logic           start;
  logic           abort;
  logic [LEN-1:0] pattern_in;
  logic [LEN-1:0] expected_in;
  logic           busy;
  logic           done;
  logic           match;
  logic [LEN-1:0] y_capture;
  logic           fsm_reset;
  logic           fsm_x;
  logic           fsm_y;
`ifdef SEQ_MISMATCH_CNT_EN
  logic [CW-1:0]  mismatch_cnt;
`endif

  modport slave (
    input  start, abort, pattern_in, expected_in, fsm_y,
`ifdef SEQ_MISMATCH_CNT_EN
    output mismatch_cnt,
`endif
    output busy, done, match, y_capture, fsm_reset, fsm_x
  );

  modport master (
    output start, abort, pattern_in, expected_in, fsm_y,
`ifdef SEQ_MISMATCH_CNT_EN
    input  mismatch_cnt,
`endif
    input  busy, done, match, y_capture, fsm_reset, fsm_x
  );
endinterface

// File: rtl/fsm_pattern_sequencer.sv
// Drives an x/y sequence-detector FSM through a LEN-bit pattern (LSB first), captures y and
// compares it with an expected word. SEQ_MISMATCH_CNT_EN adds a registered popcount of differences.
module fsm_pattern_sequencer #(
  parameter int unsigned LEN = 8
`ifdef SEQ_MISMATCH_CNT_EN
  , parameter int unsigned CW = $clog2(LEN + 1)
`endif
) (
  input logic                    clk_i,
  input logic                    reset_i,
  fsm_pattern_sequencer_if.slave bus_io
);
  localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [LEN-1:0]  shift_q, shift_d;
  logic [LEN-1:0]  exp_q, exp_d;
  logic [LEN-1:0]  ycap_q, ycap_d;
  logic [LEN-1:0]  cap_word;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            match_q, match_d;
  logic            run_last;
`ifdef SEQ_MISMATCH_CNT_EN
  logic [CW-1:0]   mis_q, mis_d, pop;
`endif

  assign run_last = (cnt_q == CntW'(LEN - 1));

  // Capture word including the bit being sampled this cycle, so DONE sees all LEN bits.
  always_comb begin
    cap_word        = ycap_q;
    cap_word[cnt_q] = bus_io.fsm_y;
  end

`ifdef SEQ_MISMATCH_CNT_EN
  always_comb begin
    pop = '0;
    for (int i = 0; i < LEN; i++) begin
      pop = pop + CW'(cap_word[i] ^ exp_q[i]);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    exp_d   = exp_q;
    ycap_d  = ycap_q;
    cnt_d   = cnt_q;
    match_d = match_q;
`ifdef SEQ_MISMATCH_CNT_EN
    mis_d   = mis_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StClr;
          shift_d = bus_io.pattern_in;
          exp_d   = bus_io.expected_in;
          ycap_d  = '0;
          cnt_d   = '0;
          match_d = 1'b0;
`ifdef SEQ_MISMATCH_CNT_EN
          mis_d   = '0;
`endif
        end
      end
      StClr: begin
        state_d = StRun;
      end
      StRun: begin
        ycap_d  = cap_word;
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (run_last) begin
          state_d = StDone;
`ifdef SEQ_MISMATCH_CNT_EN
          mis_d   = pop;
          match_d = (pop == '0);
`else
          match_d = (cap_word == exp_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over every transition and discards the bit being sampled this cycle.
    if (bus_io.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      shift_d = shift_q;
      ycap_d  = ycap_q;
      cnt_d   = cnt_q;
      match_d = 1'b0;
`ifdef SEQ_MISMATCH_CNT_EN
      mis_d   = mis_q;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      shift_q <= '0;
      exp_q   <= '0;
      ycap_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
`ifdef SEQ_MISMATCH_CNT_EN
      mis_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      exp_q   <= exp_d;
      ycap_q  <= ycap_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
`ifdef SEQ_MISMATCH_CNT_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.fsm_reset = (state_q != StRun);
  assign bus_io.fsm_x     = (state_q == StRun) & shift_q[0];
  assign bus_io.y_capture = ycap_q;
  assign bus_io.done      = (state_q == StDone) & ~bus_io.abort;
  assign bus_io.match     = match_q;
`ifdef SEQ_MISMATCH_CNT_EN
  assign bus_io.mismatch_cnt = mis_q;
`endif
endmodule

// File: tb/tb_fsm_pattern_sequencer.sv
// Scoreboard bench for fsm_pattern_sequencer (LEN=4) with a behavioural x/y FSM attached.
module tb_fsm_pattern_sequencer;
  localparam int unsigned LEN = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_cnt;
  int   runs_expected;

  typedef struct packed {
    logic [LEN-1:0] y;
    logic           m;
    logic [2:0]     mis;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [2:0] fsm_st;

  fsm_pattern_sequencer_if #(.LEN(LEN)) bus ();

  fsm_pattern_sequencer #(.LEN(LEN)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transition and output tables of the detector FSM being driven.
  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic x);
    case (s)
      3'd0:    return x ? 3'd1 : 3'd3;
      3'd1:    return x ? 3'd0 : 3'd2;
      3'd2:    return x ? 3'd0 : 3'd4;
      3'd3:    return x ? 3'd1 : 3'd3;
      default: return x ? 3'd0 : 3'd4;
    endcase
  endfunction

  function automatic logic fsm_out(input logic [2:0] s, input logic x);
    case (s)
      3'd2:    return ~x;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LEN-1:0] ref_y(input logic [LEN-1:0] p);
    logic [2:0]     s;
    logic [LEN-1:0] y;
    s = 3'd0;
    y = '0;
    for (int k = 0; k < LEN; k++) begin
      y[k] = fsm_out(s, p[k]);
      s    = fsm_next(s, p[k]);
    end
    return y;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                fsm_st <= 3'd0;
    else if (bus.fsm_reset) fsm_st <= 3'd0;
    else                    fsm_st <= fsm_next(fsm_st, bus.fsm_x);
  end
  assign bus.fsm_y = fsm_out(fsm_st, bus.fsm_x);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [LEN-1:0] p, input logic [LEN-1:0] e);
    exp_t      x;
    x.y   = ref_y(p);
    x.m   = (x.y == e);
    x.mis = 3'($countones(x.y ^ e));
    sb_q.push_back(x);
    runs_expected++;
  endtask

  // Called #1 after the accepting edge; done should appear in the 6th following cycle.
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    check("done_seen", 32'(bus.done), 32'd1);
    check("done_latency", 32'(n), 32'(LEN + 2));
  endtask

  task automatic run(input logic [LEN-1:0] p, input logic [LEN-1:0] e);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.pattern_in  = p;
    bus.expected_in = e;
    push_exp(p, e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("y_capture", 32'(bus.y_capture), 32'(mon_e.y));
        check("match", 32'(bus.match), 32'(mon_e.m));
`ifdef SEQ_MISMATCH_CNT_EN
        check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(mon_e.mis));
`endif
        check("fsm_reset_in_done", 32'(bus.fsm_reset), 32'd1);
      end
    end
    if (bus.fsm_reset) check("fsm_x_outside_run", 32'(bus.fsm_x), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LEN-1:0] p;
    logic [LEN-1:0] e;
    total = 0; bad = 0; done_cnt = 0; runs_expected = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern_in = '0; bus.expected_in = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fsm_reset", 32'(bus.fsm_reset), 32'd1);
    check("rst_fsm_x", 32'(bus.fsm_x), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_match", 32'(bus.match), 32'd0);
    check("rst_y_capture", 32'(bus.y_capture), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(4'b0001, 4'b0100);
    run(4'b0000, 4'b1110);
    run(4'b0000, 4'b0000);

    // start held through a run while pattern_in changes.
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_in = 4'b0001; bus.expected_in = 4'b0100;
    push_exp(4'b0001, 4'b0100);
    @(posedge clk);
    #1;
    bus.pattern_in = 4'b0000; bus.expected_in = 4'b1110;
    wait_done();
    push_exp(4'b0000, 4'b1110);
    @(posedge clk);
    #1;
    check("idle_between_runs", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("second_run_accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done();

    // abort in the second RUN cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_in = 4'b0001; bus.expected_in = 4'b0100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_fsm_reset", 32'(bus.fsm_reset), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_match", 32'(bus.match), 32'd0);
    bus.abort = 1'b0;
    repeat (LEN + 3) @(negedge clk);

    // async reset between edges mid-RUN.
    bus.start = 1'b1; bus.pattern_in = 4'b0000; bus.expected_in = 4'b1110;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_fsm_reset", 32'(bus.fsm_reset), 32'd1);
    check("arst_fsm_x", 32'(bus.fsm_x), 32'd0);
    check("arst_y_capture", 32'(bus.y_capture), 32'd0);
    check("arst_match", 32'(bus.match), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
`ifdef SEQ_MISMATCH_CNT_EN
    check("arst_mismatch_cnt", 32'(bus.mismatch_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run(4'b0001, 4'b0100);

    for (int i = 0; i < 24; i++) begin
      p = LEN'($urandom);
      e = ($urandom_range(0, 1) == 1) ? ref_y(p) : LEN'($urandom);
      run(p, e);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(runs_expected));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
